// File: rtl/loop_ctrl_pkg.sv
// Shared loop-control definitions for the bandwidth sequencer and the lead/lag gain stages.
//   seq_state_e : sequencer state encoding (IDLE=0, ACQ=1, TRACK=2)
//   StepWidth   : width of the acqTrackControl narrowing step
package loop_ctrl_pkg;

  localparam int unsigned StepWidth = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAcq   = 2'd1,
    StTrack = 2'd2
  } seq_state_e;

endpackage

// File: rtl/run_counter.sv
// Saturating consecutive-event counter.
//   clk, reset : clock, synchronous active-high reset
//   clk_en_i   : sample strobe; counting only happens on it
//   clr_i      : synchronous clear, independent of clk_en_i, highest priority
//   event_i    : sampled event; a 0 sample clears the run
//   thresh_i   : run length that raises hit_o; 0 behaves as 1
//   hit_o      : this sample completes a run of at least thresh_i events (combinational)
module run_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en_i,
  input  logic             clr_i,
  input  logic             event_i,
  input  logic [Width-1:0] thresh_i,
  output logic             hit_o
);

  logic [Width-1:0] count_q, count_d;
  logic [Width-1:0] count_inc;
  logic [Width-1:0] thresh_eff;

  always_comb begin
    count_inc  = (&count_q) ? count_q : count_q + 1'b1;
    thresh_eff = (thresh_i == '0) ? Width'(1) : thresh_i;
    // >= so a threshold lowered below the current run fires on the next sample
    hit_o      = clk_en_i && event_i && (count_inc >= thresh_eff);

    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (clk_en_i) begin
      count_d = event_i ? count_inc : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/loop_bw_sequencer.sv
// Acquisition/track bandwidth sequencer for the carrier/symbol loop filters.
// Holds full acquisition bandwidth until lock is stable, then narrows the loop in
// dwell-timed steps; falls back to acquisition on a sustained loss of lock.
//   clk, reset      : clock, synchronous active-high reset
//   clkEn           : loop sample strobe qualifying all counting
//   enable          : low forces IDLE
//   forceAcq        : software restart into ACQ
//   lockDetect      : lock indicator
//   lockCount       : locked-sample run to enter TRACK (0 as 1)
//   unlockCount     : unlocked-sample run to leave TRACK (0 as 1)
//   dwellCount      : clkEn samples per bandwidth step (0 disables stepping)
//   maxStep         : deepest narrowing step allowed
//   track           : high in TRACK
//   acqTrackControl : current narrowing step
//   seqState        : IDLE=0, ACQ=1, TRACK=2
//   stepPulse       : one-clk pulse whenever track or acqTrackControl changes
module loop_bw_sequencer
  import loop_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_WIDTH = 16,
  parameter int unsigned RUN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clkEn,
  input  logic                   enable,
  input  logic                   forceAcq,
  input  logic                   lockDetect,
  input  logic [RUN_WIDTH-1:0]   lockCount,
  input  logic [RUN_WIDTH-1:0]   unlockCount,
  input  logic [DWELL_WIDTH-1:0] dwellCount,
  input  logic [StepWidth-1:0]   maxStep,
  output logic                   track,
  output logic [StepWidth-1:0]   acqTrackControl,
  output logic [1:0]             seqState,
  output logic                   stepPulse
);

  seq_state_e             seq_q, seq_d;
  logic [StepWidth-1:0]   step_q, step_d;
  logic                   track_q, track_d;
  logic                   pulse_q, pulse_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH:0]   dwell_inc;

  logic lock_hit, unlock_hit;
  logic lock_clr, unlock_clr;

  // Runs only accumulate in their own state and restart on any exit.
  assign lock_clr   = forceAcq || !enable || (seq_q != StAcq) || lock_hit;
  assign unlock_clr = forceAcq || !enable || (seq_q != StTrack) || unlock_hit;

  run_counter #(
    .Width (RUN_WIDTH)
  ) u_lock_run (
    .clk      (clk),
    .reset    (reset),
    .clk_en_i (clkEn),
    .clr_i    (lock_clr),
    .event_i  (lockDetect),
    .thresh_i (lockCount),
    .hit_o    (lock_hit)
  );

  run_counter #(
    .Width (RUN_WIDTH)
  ) u_unlock_run (
    .clk      (clk),
    .reset    (reset),
    .clk_en_i (clkEn),
    .clr_i    (unlock_clr),
    .event_i  (!lockDetect),
    .thresh_i (unlockCount),
    .hit_o    (unlock_hit)
  );

  always_comb begin
    seq_d     = seq_q;
    step_d    = step_q;
    track_d   = track_q;
    dwell_d   = dwell_q;
    dwell_inc = {1'b0, dwell_q} + 1'b1;

    if (forceAcq || !enable) begin
      seq_d   = forceAcq ? StAcq : StIdle;
      step_d  = '0;
      track_d = 1'b0;
      dwell_d = '0;
    end else begin
      unique case (seq_q)
        StIdle: begin
          seq_d = StAcq;
        end
        StAcq: begin
          if (lock_hit) begin
            seq_d   = StTrack;
            track_d = 1'b1;
            step_d  = '0;
            dwell_d = '0;
          end
        end
        StTrack: begin
          // Loss-of-lock exit outranks both the clamp and a coincident dwell expiry.
          if (unlock_hit) begin
            seq_d   = StAcq;
            track_d = 1'b0;
            step_d  = '0;
            dwell_d = '0;
          end else if (maxStep < step_q) begin
            step_d  = maxStep;
            dwell_d = '0;
          end else if (clkEn && (dwellCount != '0) && (step_q < maxStep)) begin
            if (dwell_inc >= {1'b0, dwellCount}) begin
              step_d  = step_q + 1'b1;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_inc[DWELL_WIDTH-1:0];
            end
          end
        end
        default: begin
          seq_d   = StIdle;
          step_d  = '0;
          track_d = 1'b0;
          dwell_d = '0;
        end
      endcase
    end

    pulse_d = (track_d != track_q) || (step_d != step_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q   <= StIdle;
      step_q  <= '0;
      track_q <= 1'b0;
      pulse_q <= 1'b0;
      dwell_q <= '0;
    end else begin
      seq_q   <= seq_d;
      step_q  <= step_d;
      track_q <= track_d;
      pulse_q <= pulse_d;
      dwell_q <= dwell_d;
    end
  end

  assign track           = track_q;
  assign acqTrackControl = step_q;
  assign seqState        = seq_q;
  assign stepPulse       = pulse_q;

endmodule

// File: tb/tb_loop_bw_sequencer.sv
// Directed bench for loop_bw_sequencer: acquire, stepping, loss of lock, coincident
// exit/dwell expiry, clamp, forceAcq, enable and reset overrides.
module tb_loop_bw_sequencer;

  logic        clk;
  logic        reset;
  logic        clkEn;
  logic        enable;
  logic        forceAcq;
  logic        lockDetect;
  logic [7:0]  lockCount;
  logic [7:0]  unlockCount;
  logic [15:0] dwellCount;
  logic [1:0]  maxStep;
  logic        track;
  logic [1:0]  acqTrackControl;
  logic [1:0]  seqState;
  logic        stepPulse;

  int n_checks = 0;
  int n_fail   = 0;

  loop_bw_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .clkEn           (clkEn),
    .enable          (enable),
    .forceAcq        (forceAcq),
    .lockDetect      (lockDetect),
    .lockCount       (lockCount),
    .unlockCount     (unlockCount),
    .dwellCount      (dwellCount),
    .maxStep         (maxStep),
    .track           (track),
    .acqTrackControl (acqTrackControl),
    .seqState        (seqState),
    .stepPulse       (stepPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One loop sample: three idle clocks, then a clkEn clock; returns just after the
  // edge that registered the decision for that sample.
  task automatic smp(input logic lock);
    lockDetect = lock;
    repeat (3) tick();
    clkEn = 1'b1;
    tick();
    clkEn = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int st, input int trk, input int step,
                         input int pls);
    chk({tag, ".seqState"}, int'(seqState), st);
    chk({tag, ".track"}, int'(track), trk);
    chk({tag, ".acqTrackControl"}, int'(acqTrackControl), step);
    chk({tag, ".stepPulse"}, int'(stepPulse), pls);
  endtask

  initial begin
    reset       = 1'b1;
    clkEn       = 1'b0;
    enable      = 1'b0;
    forceAcq    = 1'b0;
    lockDetect  = 1'b0;
    lockCount   = 8'd4;
    unlockCount = 8'd3;
    dwellCount  = 16'd0;
    maxStep     = 2'd3;
    tick();
    tick();
    chk_out("reset", 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_out("idle_disabled", 0, 0, 0, 0);

    enable = 1'b1;
    tick();
    chk_out("idle_to_acq", 1, 0, 0, 0);

    // Acquire: a broken run of 3 does not count, then a full run of 4.
    repeat (3) smp(1'b1);
    chk_out("run3", 1, 0, 0, 0);
    smp(1'b0);
    chk_out("run_broken", 1, 0, 0, 0);
    repeat (3) smp(1'b1);
    chk_out("run2_3", 1, 0, 0, 0);
    smp(1'b1);
    chk_out("enter_track", 2, 1, 0, 1);
    tick();
    chk("pulse_one_clk", int'(stepPulse), 0);

    // dwellCount=0: no stepping.
    repeat (12) smp(1'b1);
    chk_out("no_dwell", 2, 1, 0, 0);

    // Stepping every 10 samples up to maxStep=3, then hold.
    dwellCount = 16'd10;
    repeat (9) smp(1'b1);
    chk_out("dwell9", 2, 1, 0, 0);
    smp(1'b1);
    chk_out("step1", 2, 1, 1, 1);
    repeat (10) smp(1'b1);
    chk_out("step2", 2, 1, 2, 1);
    repeat (10) smp(1'b1);
    chk_out("step3", 2, 1, 3, 1);
    repeat (10) smp(1'b1);
    chk_out("step_hold", 2, 1, 3, 0);

    // Clamp without clkEn.
    maxStep = 2'd1;
    tick();
    chk_out("clamp", 2, 1, 1, 1);
    tick();
    chk_out("clamp_hold", 2, 1, 1, 0);
    maxStep = 2'd3;
    repeat (10) smp(1'b1);
    chk_out("reach_step2", 2, 1, 2, 1);

    // Loss of lock at step 2, stepping off.
    dwellCount = 16'd0;
    repeat (2) smp(1'b0);
    smp(1'b1);
    chk_out("unlock_interrupted", 2, 1, 2, 0);
    repeat (2) smp(1'b0);
    chk_out("unlock2", 2, 1, 2, 0);
    smp(1'b0);
    chk_out("unlock_exit", 1, 0, 0, 1);

    // Coincident loss of lock and dwell expiry.
    repeat (4) smp(1'b1);
    chk_out("reacq", 2, 1, 0, 1);
    dwellCount = 16'd5;
    repeat (2) smp(1'b1);
    repeat (2) smp(1'b0);
    chk_out("coinc_pre", 2, 1, 0, 0);
    smp(1'b0);
    chk_out("coinc_exit", 1, 0, 0, 1);
    tick();
    chk("coinc_single_pulse", int'(stepPulse), 0);

    // forceAcq mid-dwell at step 1.
    dwellCount = 16'd10;
    repeat (4) smp(1'b1);
    chk_out("reacq2", 2, 1, 0, 1);
    repeat (15) smp(1'b1);
    chk_out("mid_dwell", 2, 1, 1, 0);
    forceAcq = 1'b1;
    tick();
    forceAcq = 1'b0;
    chk_out("force_acq", 1, 0, 0, 1);
    repeat (3) smp(1'b1);
    chk_out("force_cleared_run", 1, 0, 0, 0);
    smp(1'b1);
    chk_out("reacq3", 2, 1, 0, 1);

    // enable low forces IDLE.
    enable = 1'b0;
    tick();
    chk_out("disable", 0, 0, 0, 1);
    enable = 1'b1;
    tick();
    chk_out("reenable", 1, 0, 0, 0);

    // lockCount=0 behaves as 1.
    lockCount = 8'd0;
    smp(1'b1);
    chk_out("lockcount0", 2, 1, 0, 1);

    // Reset mid-TRACK at step 1.
    dwellCount = 16'd2;
    repeat (2) smp(1'b1);
    chk_out("pre_reset", 2, 1, 1, 1);
    reset = 1'b1;
    tick();
    chk_out("reset_mid_track", 0, 0, 0, 0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
